// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared state encodings and default widths for the up/down sweep sequencer.
package updown_sweep_ctrl_pkg;

    localparam int N_DEF  = 4;
    localparam int PW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_counter_core.sv
// Loadable N-bit up/down counter; load wins over enable, direction is taken
// combinationally from up_down so a direction change applies on the same edge.
module updown_counter_core
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] R,
    input  logic         L,
    input  logic         E,
    input  logic         up_down,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] q_reg;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            q_reg <= '0;
        end else if (L) begin
            q_reg <= R;
        end else if (E) begin
            q_reg <= up_down ? (q_reg + ONE) : (q_reg - ONE);
        end
    end

    assign Q = q_reg;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: accepts (lo, hi, passes) and drives the counter core through
// lo->hi->lo triangle passes, with abort, reject and completion reporting.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic [N-1:0]  lo,
    input  logic [N-1:0]  hi,
    input  logic [PW-1:0] passes,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          dir,
    output logic [N-1:0]  Q
);

    localparam logic [N-1:0]  Q_ONE    = N'(1);
    localparam logic [PW-1:0] PASS_ONE = PW'(1);

    state_t        state_reg;
    logic [N-1:0]  lo_reg;
    logic [N-1:0]  hi_reg;
    logic [PW-1:0] passes_reg;
    logic [PW-1:0] pass_cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;
    logic          dir_reg;

    logic          load;
    logic          enable;
    logic          count_up;
    logic [N-1:0]  q_up;
    logic [N-1:0]  q_dn;
    logic [PW-1:0] pass_inc;
    logic          cmd_ok;

    // Counter controls are decoded from the current state; stop freezes Q in
    // the very cycle it is seen, which is what gives it priority over a bound hit.
    assign load     = (state_reg == ST_LOAD);
    assign enable   = ((state_reg == ST_UP) || (state_reg == ST_DOWN)) && !stop;
    assign count_up = (state_reg != ST_DOWN);
    assign q_up     = Q + Q_ONE;
    assign q_dn     = Q - Q_ONE;
    assign pass_inc = pass_cnt_reg + PASS_ONE;
    assign cmd_ok   = (lo < hi) && (passes != '0);

    updown_counter_core #(
        .N(N)
    ) u_core (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .R       (lo_reg),
        .L       (load),
        .E       (enable),
        .up_down (count_up),
        .Q       (Q)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg    <= ST_IDLE;
            lo_reg       <= '0;
            hi_reg       <= '0;
            passes_reg   <= '0;
            pass_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            dir_reg      <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            lo_reg       <= lo;
                            hi_reg       <= hi;
                            passes_reg   <= passes;
                            pass_cnt_reg <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= ST_LOAD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    dir_reg   <= 1'b1;
                    state_reg <= ST_UP;
                end
                ST_UP: begin
                    if (stop) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (q_up == hi_reg) begin
                        dir_reg   <= 1'b0;
                        state_reg <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (stop) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (q_dn == lo_reg) begin
                        pass_cnt_reg <= pass_inc;
                        if (pass_inc == passes_reg) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            dir_reg   <= 1'b1;
                            state_reg <= ST_UP;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign dir  = dir_reg;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: sweeps, rejects, aborts and mid-sweep
// reset, every expected value hand-derived from the sweep behaviour.
module tb_updown_sweep_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       start;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] passes;
    logic       stop;
    logic       busy;
    logic       done;
    logic       err;
    logic       dir;
    logic [3:0] Q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    updown_sweep_ctrl #(
        .N  (4),
        .PW (4)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .stop   (stop),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .dir    (dir),
        .Q      (Q)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Full sweep with a cycle-by-cycle expected trace. With noise set, valid
    // start pulses are injected during UP and during DONE and must be ignored.
    task automatic run_sweep(input string tag, input logic [3:0] l, input logic [3:0] h,
                             input logic [3:0] p, input bit noise, output int toggles);
        int   span;
        int   busy_cycles;
        logic prev_dir;
        bit   last;
        span        = int'(h) - int'(l);
        busy_cycles = 0;
        toggles     = 0;
        prev_dir    = dir;
        lo = l; hi = h; passes = p; start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, " accept busy"}, busy, 1);
        check_val({tag, " accept err"}, err, 0);
        if (busy) busy_cycles++;
        tick();
        if (dir !== prev_dir) toggles++;
        prev_dir = dir;
        if (busy) busy_cycles++;
        check_val({tag, " load Q"}, Q, l);
        check_val({tag, " load dir"}, dir, 1);
        for (int pp = 1; pp <= int'(p); pp++) begin
            for (int k = 1; k <= span; k++) begin
                if (noise && pp == 1 && k == 1) begin
                    start = 1'b1; lo = 4'd0; hi = 4'd1; passes = 4'd1;
                end
                tick();
                start = 1'b0;
                if (dir !== prev_dir) toggles++;
                prev_dir = dir;
                if (busy) busy_cycles++;
                check_val({tag, " up Q"}, Q, int'(l) + k);
                check_val({tag, " up dir"}, dir, (k == span) ? 0 : 1);
                check_val({tag, " up done"}, done, 0);
            end
            for (int k = 1; k <= span; k++) begin
                tick();
                if (dir !== prev_dir) toggles++;
                prev_dir = dir;
                if (busy) busy_cycles++;
                last = (k == span) && (pp == int'(p));
                check_val({tag, " down Q"}, Q, int'(h) - k);
                check_val({tag, " down dir"}, dir, (k == span && !last) ? 1 : 0);
                check_val({tag, " down done"}, done, last ? 1 : 0);
                check_val({tag, " down busy"}, busy, last ? 0 : 1);
            end
        end
        check_val({tag, " busy cycles"}, busy_cycles, 1 + 2 * span * int'(p));
        if (noise) begin
            start = 1'b1; lo = 4'd3; hi = 4'd8; passes = 4'd2;
        end
        tick();
        start = 1'b0;
        check_val({tag, " after done"}, done, 0);
        check_val({tag, " after busy"}, busy, 0);
        check_val({tag, " after Q"}, Q, l);
        tick();
        check_val({tag, " idle busy"}, busy, 0);
        check_val({tag, " idle err"}, err, 0);
        $display("sweep %s lo=%0d hi=%0d passes=%0d busy_cycles=%0d dir_toggles=%0d",
                 tag, l, h, p, busy_cycles, toggles);
    endtask

    task automatic reject(input string tag, input logic [3:0] l, input logic [3:0] h,
                          input logic [3:0] p, input logic [3:0] q_hold);
        lo = l; hi = h; passes = p; start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, " err"}, err, 1);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " Q"}, Q, q_hold);
        tick();
        check_val({tag, " err clear"}, err, 0);
        check_val({tag, " still idle"}, busy, 0);
        $display("reject %s lo=%0d hi=%0d passes=%0d", tag, l, h, p);
    endtask

    // Start lo=1,hi=9,passes=1 and raise stop once Q shows stop_at while counting up.
    task automatic abort_at(input string tag, input logic [3:0] stop_at);
        lo = 4'd1; hi = 4'd9; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 20 && Q != stop_at; i++) tick();
        check_val({tag, " reached"}, Q, stop_at);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val({tag, " Q hold"}, Q, stop_at);
        check_val({tag, " done"}, done, 1);
        check_val({tag, " busy"}, busy, 0);
        tick();
        check_val({tag, " done clear"}, done, 0);
        check_val({tag, " Q after"}, Q, stop_at);
        $display("abort %s at Q=%0d", tag, stop_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg;
        Resetn = 1'b0; start = 1'b0; stop = 1'b0;
        lo = 4'd0; hi = 4'd0; passes = 4'd0;
        tick();
        tick();
        check_val("reset Q", Q, 0);
        check_val("reset busy", busy, 0);
        check_val("reset done", done, 0);
        check_val("reset err", err, 0);
        check_val("reset dir", dir, 1);
        Resetn = 1'b1;
        tick();
        $display("reset released");

        run_sweep("basic", 4'd2, 4'd4, 4'd1, 1'b0, tg);
        check_val("basic end dir", dir, 0);
        run_sweep("extreme", 4'd0, 4'd15, 4'd2, 1'b0, tg);
        check_val("extreme dir toggles", tg, 4);

        reject("equal", 4'd5, 4'd5, 4'd1, 4'd0);
        reject("inverted", 4'd7, 4'd3, 4'd1, 4'd0);
        reject("zero passes", 4'd2, 4'd6, 4'd0, 4'd0);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("idle stop done", done, 0);
        check_val("idle stop busy", busy, 0);

        abort_at("mid up", 4'd6);
        abort_at("at hi", 4'd9);
        abort_at("before hi", 4'd8);

        // Reset while counting down through Q=3.
        lo = 4'd1; hi = 4'd5; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_val("midreset pre Q", Q, 3);
        check_val("midreset pre dir", dir, 0);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        check_val("midreset Q", Q, 0);
        check_val("midreset busy", busy, 0);
        check_val("midreset done", done, 0);
        check_val("midreset dir", dir, 1);
        tick();
        check_val("midreset no done", done, 0);
        check_val("midreset idle", busy, 0);
        $display("reset mid-sweep at Q=3");

        run_sweep("noisy", 4'd2, 4'd4, 4'd1, 1'b1, tg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
